// File: rtl/plru_victim_alloc.sv
// Victim selection and allocate/fill handshake around a PLRU; owns the per-entry valid bits.
// Optional build macro VICTIM_ALLOC_INVALID_FIRST_EN prefers the lowest-index invalid entry as victim.
module plru_victim_alloc #(
  parameter int ENTRY_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hit_valid_i,
  input  logic [ENTRY_COUNT-1:0] hit_mask_i,
  input  logic                   alloc_req_i,
  output logic                   alloc_gnt_o,
  output logic [ENTRY_COUNT-1:0] alloc_mask_o,
  input  logic                   fill_done_i,
  input  logic                   inval_i,
  input  logic [ENTRY_COUNT-1:0] inval_mask_i,
  input  logic                   flush_i,
  input  logic [ENTRY_COUNT-1:0] plru_mask_i,
  output logic [ENTRY_COUNT-1:0] access_mask_o,
  output logic [ENTRY_COUNT-1:0] valid_mask_o,
  output logic                   busy_o
);

  localparam logic [ENTRY_COUNT-1:0] ENTRY0_MASK = {{(ENTRY_COUNT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t                 state_r;
  logic [ENTRY_COUNT-1:0] valid_r;
  logic                   alloc_gnt_r;
  logic [ENTRY_COUNT-1:0] alloc_mask_r;
  logic [ENTRY_COUNT-1:0] access_mask_r;
  logic                   busy_r;

  logic [ENTRY_COUNT-1:0] plru_pick_s;
  logic [ENTRY_COUNT-1:0] victim_s;
  logic [ENTRY_COUNT-1:0] inval_clr_s;
  logic                   hit_ok_s;
`ifdef VICTIM_ALLOC_INVALID_FIRST_EN
  logic [ENTRY_COUNT-1:0] free_pick_s;
`endif

  function automatic logic is_onehot(input logic [ENTRY_COUNT-1:0] m);
    return (m != '0) && ((m & (m - ENTRY0_MASK)) == '0);
  endfunction

  function automatic logic [ENTRY_COUNT-1:0] lowest_invalid(input logic [ENTRY_COUNT-1:0] v);
    logic [ENTRY_COUNT-1:0] sel;
    sel = '0;
    for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
      if (!v[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

  // Victim choice, qualified hit and invalidate mask for the current cycle
  always_comb begin
    plru_pick_s = is_onehot(plru_mask_i) ? plru_mask_i : ENTRY0_MASK;
`ifdef VICTIM_ALLOC_INVALID_FIRST_EN
    free_pick_s = lowest_invalid(valid_r);
    if (free_pick_s != '0) begin
      victim_s = free_pick_s;
    end else begin
      victim_s = plru_pick_s;
    end
`else
    victim_s = plru_pick_s;
`endif
    hit_ok_s    = hit_valid_i && ((hit_mask_i & valid_r) != '0);
    inval_clr_s = inval_i ? inval_mask_i : '0;
  end

  // Allocation FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      valid_r       <= '0;
      alloc_gnt_r   <= 1'b0;
      alloc_mask_r  <= '0;
      access_mask_r <= '0;
      busy_r        <= 1'b0;
    end else if (flush_i) begin
      state_r       <= ST_IDLE;
      valid_r       <= '0;
      alloc_gnt_r   <= 1'b0;
      alloc_mask_r  <= '0;
      access_mask_r <= '0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          access_mask_r <= hit_ok_s ? hit_mask_i : '0;
          if (alloc_req_i) begin
            // victim loses its valid bit so it cannot hit mid-replacement
            state_r      <= ST_FILL;
            alloc_gnt_r  <= 1'b1;
            alloc_mask_r <= victim_s;
            busy_r       <= 1'b1;
            valid_r      <= valid_r & ~victim_s & ~inval_clr_s;
          end else begin
            alloc_gnt_r  <= 1'b0;
            alloc_mask_r <= '0;
            busy_r       <= 1'b0;
            valid_r      <= valid_r & ~inval_clr_s;
          end
        end
        ST_FILL: begin
          alloc_gnt_r <= 1'b0;
          if (fill_done_i) begin
            // fill beats a same-cycle hit; invalidate beats the fill's set
            state_r       <= ST_IDLE;
            alloc_mask_r  <= '0;
            busy_r        <= 1'b0;
            access_mask_r <= alloc_mask_r;
            valid_r       <= (valid_r | alloc_mask_r) & ~inval_clr_s;
          end else begin
            access_mask_r <= hit_ok_s ? hit_mask_i : '0;
            valid_r       <= valid_r & ~inval_clr_s;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          valid_r       <= '0;
          alloc_gnt_r   <= 1'b0;
          alloc_mask_r  <= '0;
          access_mask_r <= '0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign alloc_gnt_o   = alloc_gnt_r;
  assign alloc_mask_o  = alloc_mask_r;
  assign access_mask_o = access_mask_r;
  assign valid_mask_o  = valid_r;
  assign busy_o        = busy_r;

endmodule

// File: tb/tb_plru_victim_alloc.sv
// Self-checking bench for plru_victim_alloc: directed vector table, async-reset sequence,
// then randomized traffic against an index/array based reference model.
module tb_plru_victim_alloc;

  logic       clk = 1'b0;
  logic       rst;
  logic       hit_valid_i;
  logic [3:0] hit_mask_i;
  logic       alloc_req_i;
  logic       alloc_gnt_o;
  logic [3:0] alloc_mask_o;
  logic       fill_done_i;
  logic       inval_i;
  logic [3:0] inval_mask_i;
  logic       flush_i;
  logic [3:0] plru_mask_i;
  logic [3:0] access_mask_o;
  logic [3:0] valid_mask_o;
  logic       busy_o;

  always #5 clk = ~clk;

  plru_victim_alloc #(.ENTRY_COUNT(4)) dut (
    .clk(clk), .rst(rst),
    .hit_valid_i(hit_valid_i), .hit_mask_i(hit_mask_i),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_mask_o(alloc_mask_o),
    .fill_done_i(fill_done_i), .inval_i(inval_i), .inval_mask_i(inval_mask_i),
    .flush_i(flush_i), .plru_mask_i(plru_mask_i),
    .access_mask_o(access_mask_o), .valid_mask_o(valid_mask_o), .busy_o(busy_o)
  );

  int checks   = 0;
  int failures = 0;

  // expected layout: {gnt, alloc_mask, access_mask, valid_mask, busy}
  typedef struct {
    logic       hv;
    logic [3:0] hm;
    logic       ar;
    logic       fd;
    logic       iv;
    logic [3:0] im;
    logic       fl;
    logic [3:0] pm;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(input logic hv, input logic [3:0] hm, input logic ar, input logic fd,
                              input logic iv, input logic [3:0] im, input logic fl, input logic [3:0] pm,
                              input logic g, input logic [3:0] am, input logic [3:0] ac,
                              input logic [3:0] vm, input logic b);
    vec_t v;
    v.hv = hv; v.hm = hm; v.ar = ar; v.fd = fd; v.iv = iv; v.im = im; v.fl = fl; v.pm = pm;
    v.exp = {g, am, ac, vm, b};
    return v;
  endfunction

  task automatic drive(input logic hv, input logic [3:0] hm, input logic ar, input logic fd,
                       input logic iv, input logic [3:0] im, input logic fl, input logic [3:0] pm);
    hit_valid_i = hv; hit_mask_i = hm; alloc_req_i = ar; fill_done_i = fd;
    inval_i = iv; inval_mask_i = im; flush_i = fl; plru_mask_i = pm;
  endtask

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] got;
    got = {alloc_gnt_o, alloc_mask_o, access_mask_o, valid_mask_o, busy_o};
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures < 25)
        $display("FAIL %s got{gnt,alloc,acc,valid,busy}=%b required=%b", name, got, exp);
    end
  endtask

  // reference model: entries as a bit array, victim as an index
  bit         m_valid[4];
  bit         m_fill;
  int         m_vic;
  logic       r_hv, r_ar, r_fd, r_iv, r_fl;
  logic [3:0] r_im, r_pm;
  int         r_hi;

  task automatic model_step(output logic [13:0] exp);
    int acc;
    bit g;
    int cnt;
    int idx;
    logic [3:0] am, ac, vm;
    acc = -1;
    g   = 1'b0;
    if (r_fl) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
      m_fill = 1'b0;
    end else begin
      if (m_fill) begin
        if (r_fd) begin
          m_valid[m_vic] = 1'b1;
          acc = m_vic;
          m_fill = 1'b0;
        end else if (r_hv && m_valid[r_hi]) begin
          acc = r_hi;
        end
      end else begin
        if (r_hv && m_valid[r_hi]) acc = r_hi;
        if (r_ar) begin
          cnt = 0;
          idx = 0;
          for (int i = 0; i < 4; i++) if (r_pm[i]) begin cnt++; idx = i; end
          m_vic = (cnt == 1) ? idx : 0;
`ifdef VICTIM_ALLOC_INVALID_FIRST_EN
          for (int i = 3; i >= 0; i--) if (!m_valid[i]) m_vic = i;
`endif
          m_valid[m_vic] = 1'b0;
          m_fill = 1'b1;
          g = 1'b1;
        end
      end
      if (r_iv) for (int i = 0; i < 4; i++) if (r_im[i]) m_valid[i] = 1'b0;
    end
    am = 4'b0000;
    ac = 4'b0000;
    if (m_fill) am[m_vic] = 1'b1;
    if (acc >= 0) ac[acc] = 1'b1;
    for (int i = 0; i < 4; i++) vm[i] = m_valid[i];
    exp = {g, am, ac, vm, m_fill};
  endtask

  initial begin
    logic [13:0] e;
    //               hv hm      ar fd iv im      fl pm        g  am      ac      vm      b
    tbl[0]  = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 1);
    tbl[1]  = mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0001, 4'b0001, 0);
    tbl[2]  = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0010, 1, 4'b0010, 4'b0000, 4'b0001, 1);
    tbl[3]  = mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0010, 4'b0011, 0);
    tbl[4]  = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0100, 1, 4'b0100, 4'b0000, 4'b0011, 1);
    tbl[5]  = mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0100, 4'b0111, 0);
    tbl[6]  = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b1000, 1, 4'b1000, 4'b0000, 4'b0111, 1);
    tbl[7]  = mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1000, 4'b1111, 0);
    tbl[8]  = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0100, 1, 4'b0100, 4'b0000, 4'b1011, 1);
    tbl[9]  = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 4'b0100, 4'b0000, 4'b1011, 1);
    tbl[10] = mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0100, 4'b1111, 0);
    tbl[11] = mk(1, 4'b0010, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0010, 4'b1111, 0);
    tbl[12] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b1000, 1, 4'b1000, 4'b0000, 4'b0111, 1);
    tbl[13] = mk(1, 4'b0001, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1000, 4'b1111, 0);
    tbl[14] = mk(0, 4'b0000, 0, 0, 1, 4'b0001, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1110, 0);
    tbl[15] = mk(1, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b1110, 0);
    tbl[16] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0000, 1, 4'b0001, 4'b0000, 4'b1110, 1);
    tbl[17] = mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0001, 4'b1111, 0);
    tbl[18] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0110, 1, 4'b0001, 4'b0000, 4'b1110, 1);
    tbl[19] = mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0001, 4'b1111, 0);
    tbl[20] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0010, 1, 4'b0010, 4'b0000, 4'b1101, 1);
    tbl[21] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0100, 0, 4'b0010, 4'b0000, 4'b1101, 1);
    tbl[22] = mk(0, 4'b0000, 0, 1, 1, 4'b0010, 0, 4'b0000, 0, 4'b0000, 4'b0010, 4'b1101, 0);
    tbl[23] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0010, 1, 4'b0010, 4'b0000, 4'b1101, 1);
    tbl[24] = mk(0, 4'b0000, 0, 0, 1, 4'b0010, 0, 4'b0000, 0, 4'b0010, 4'b0000, 4'b1101, 1);
    tbl[25] = mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0010, 4'b1111, 0);
    tbl[26] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b1110, 1);
    tbl[27] = mk(1, 4'b0100, 0, 1, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[28] = mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    tbl[29] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, 0);

    rst = 1'b1;
    drive(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000);
    repeat (2) @(negedge clk);
    check("reset", 14'd0);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].hv, tbl[i].hm, tbl[i].ar, tbl[i].fd, tbl[i].iv, tbl[i].im, tbl[i].fl, tbl[i].pm);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // async reset while in FILL
    drive(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0001);
    @(negedge clk);
    check("rst_pre_grant", {1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1});
    drive(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", 14'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0010);
    @(negedge clk);
    check("post_rst_grant", {1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1});
    drive(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000);
    @(negedge clk);
    check("post_rst_fill", {1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b0});
    drive(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000);
    @(negedge clk);
    check("flush_idle", 14'd0);

    // randomized traffic against the model
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_fill = 1'b0;
    m_vic  = 0;
    for (int n = 0; n < 3000; n++) begin
      r_hv = 1'($urandom_range(0, 1));
      r_hi = int'($urandom_range(0, 3));
      r_ar = ($urandom_range(0, 2) != 0);
      r_fd = m_fill && ($urandom_range(0, 2) == 0);
      r_iv = ($urandom_range(0, 7) == 0);
      r_im = 4'($urandom_range(0, 15));
      r_fl = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 7) == 0) r_pm = 4'($urandom_range(0, 15));
      else r_pm = 4'b0001 << $urandom_range(0, 3);
      drive(r_hv, 4'b0001 << r_hi, r_ar, r_fd, r_iv, r_im, r_fl, r_pm);
      model_step(e);
      @(negedge clk);
      check("rand", e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
